// File: rtl/axioma_timer_counter8_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axioma_timer_counter8_if : control/status bundle of the 8-bit timer/counter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface axioma_timer_counter8_if #(
  parameter int WIDTH = 8
);
  logic             timer_tick;
  logic [2:0]       clk_sel;
  logic             t_pin;
  logic [1:0]       mode;
  logic             ocr_wr;
  logic [WIDTH-1:0] ocr_wdata;
  logic             tcnt_wr;
  logic [WIDTH-1:0] tcnt_wdata;
  logic [1:0]       flag_clr;
  logic [WIDTH-1:0] tcnt;
  logic [WIDTH-1:0] ocr_active;
  logic             ov_flag;
  logic             ocf_flag;
  logic             oc_out;

  modport master (
    output timer_tick, clk_sel, t_pin, mode, ocr_wr, ocr_wdata,
           tcnt_wr, tcnt_wdata, flag_clr,
    input  tcnt, ocr_active, ov_flag, ocf_flag, oc_out
  );

  modport slave (
    input  timer_tick, clk_sel, t_pin, mode, ocr_wr, ocr_wdata,
           tcnt_wr, tcnt_wdata, flag_clr,
    output tcnt, ocr_active, ov_flag, ocf_flag, oc_out
  );
endinterface
`default_nettype wire

// File: rtl/axioma_timer_counter8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axioma_timer_counter8 : 8-bit timer/counter with Normal/CTC/Fast-PWM modes
// Revision: 1.0
// ---------------------------------------------------------------------------
module axioma_timer_counter8 #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire                           clk,
  input  wire                           reset,
  axioma_timer_counter8_if.slave        bus
);
  localparam logic [WIDTH-1:0] c_MAX      = {WIDTH{1'b1}};
  localparam logic [1:0]       c_MODE_CTC = 2'b01;
  localparam logic [1:0]       c_MODE_PWM = 2'b10;
  localparam logic [2:0]       c_SEL_STOP = 3'b000;
  localparam logic [2:0]       c_SEL_FALL = 3'b110;
  localparam logic [2:0]       c_SEL_RISE = 3'b111;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pin_d;
  logic [WIDTH-1:0]       r_tcnt;
  logic [WIDTH-1:0]       r_ocr_buf;
  logic [WIDTH-1:0]       r_ocr_active;
  logic                   r_ov;
  logic                   r_ocf;
  logic                   r_oc;

  logic                   w_pin_s;
  logic                   w_count_en;
  logic                   w_is_pwm;
  logic                   w_match;
  logic                   w_at_max;
  logic [WIDTH-1:0]       w_tcnt_inc;
  logic [WIDTH-1:0]       w_tcnt_nxt;
  logic [WIDTH-1:0]       w_ocr_nxt;
  logic                   w_ov_set;
  logic                   w_ocf_set;
  logic                   w_oc_nxt;

  assign w_pin_s    = r_sync[SYNC_STAGES-1];
  assign w_is_pwm   = (bus.mode == c_MODE_PWM);
  assign w_match    = (r_tcnt == r_ocr_active);
  assign w_at_max   = (r_tcnt == c_MAX);
  assign w_tcnt_inc = r_tcnt + 1'b1;

  always_comb begin
    w_count_en = 1'b0;
    case (bus.clk_sel)
      c_SEL_STOP: w_count_en = 1'b0;
      c_SEL_FALL: w_count_en = r_pin_d & ~w_pin_s;
      c_SEL_RISE: w_count_en = w_pin_s & ~r_pin_d;
      default:    w_count_en = bus.timer_tick;
    endcase
  end

  always_comb begin
    w_tcnt_nxt = r_tcnt;
    w_ov_set   = 1'b0;
    w_ocf_set  = 1'b0;
    w_oc_nxt   = r_oc;
    w_ocr_nxt  = r_ocr_active;

    // A CPU write suppresses match, overflow and the PWM double-buffer update
    if (bus.tcnt_wr) begin
      w_tcnt_nxt = bus.tcnt_wdata;
    end else if (w_count_en) begin
      w_ocf_set = w_match;
      if ((bus.mode == c_MODE_CTC) && w_match) begin
        w_tcnt_nxt = '0;
      end else begin
        w_tcnt_nxt = w_tcnt_inc;
        w_ov_set   = w_at_max;
      end
      if (w_is_pwm) begin
        w_oc_nxt = (w_tcnt_nxt <= r_ocr_active);
      end else if (w_match) begin
        w_oc_nxt = ~r_oc;
      end
    end

    // Outside PWM the buffer mirrors the active value, so leaving PWM reloads it
    if (!w_is_pwm) begin
      w_ocr_nxt = bus.ocr_wr ? bus.ocr_wdata : r_ocr_buf;
    end else if (w_count_en && !bus.tcnt_wr && w_at_max) begin
      w_ocr_nxt = r_ocr_buf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync       <= '0;
      r_pin_d      <= 1'b0;
      r_tcnt       <= '0;
      r_ocr_buf    <= '0;
      r_ocr_active <= '0;
      r_ov         <= 1'b0;
      r_ocf        <= 1'b0;
      r_oc         <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], bus.t_pin};
      r_pin_d      <= w_pin_s;
      r_tcnt       <= w_tcnt_nxt;
      r_ocr_active <= w_ocr_nxt;
      r_oc         <= w_oc_nxt;
      if (bus.ocr_wr) begin
        r_ocr_buf <= bus.ocr_wdata;
      end
      if (w_ov_set) begin
        r_ov <= 1'b1;
      end else if (bus.flag_clr[0]) begin
        r_ov <= 1'b0;
      end
      if (w_ocf_set) begin
        r_ocf <= 1'b1;
      end else if (bus.flag_clr[1]) begin
        r_ocf <= 1'b0;
      end
    end
  end

  assign bus.tcnt       = r_tcnt;
  assign bus.ocr_active = r_ocr_active;
  assign bus.ov_flag    = r_ov;
  assign bus.ocf_flag   = r_ocf;
  assign bus.oc_out     = r_oc;

endmodule
`default_nettype wire

// File: tb/tb_axioma_timer_counter8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axioma_timer_counter8 : directed self-checking bench for the timer core
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_axioma_timer_counter8;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  axioma_timer_counter8_if #(.WIDTH(8)) bus ();

  axioma_timer_counter8 #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.timer_tick = 1'b0;
    bus.clk_sel    = 3'b000;
    bus.mode       = 2'b00;
    bus.ocr_wr     = 1'b0;
    bus.ocr_wdata  = 8'h00;
    bus.tcnt_wr    = 1'b0;
    bus.tcnt_wdata = 8'h00;
    bus.flag_clr   = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    checks++; if (bus.tcnt !== 8'h00) begin errors++; $display("FAIL reset_tcnt got %h want 00", bus.tcnt); end
    checks++; if (bus.ocr_active !== 8'h00) begin errors++; $display("FAIL reset_ocr got %h want 00", bus.ocr_active); end
    checks++; if (bus.ov_flag !== 1'b0) begin errors++; $display("FAIL reset_ov got %b want 0", bus.ov_flag); end
    checks++; if (bus.ocf_flag !== 1'b0) begin errors++; $display("FAIL reset_ocf got %b want 0", bus.ocf_flag); end
    checks++; if (bus.oc_out !== 1'b0) begin errors++; $display("FAIL reset_oc got %b want 0", bus.oc_out); end
  endtask

  task automatic test_normal();
    bus.mode = 2'b00; bus.clk_sel = 3'b001; bus.timer_tick = 1'b1;
    bus.tcnt_wr = 1'b1; bus.tcnt_wdata = 8'hFD;
    tick(1);
    bus.tcnt_wr = 1'b0;
    checks++; if (bus.tcnt !== 8'hFD) begin errors++; $display("FAIL norm_write got %h want FD", bus.tcnt); end
    tick(1);
    checks++; if (bus.tcnt !== 8'hFE) begin errors++; $display("FAIL norm_fe got %h want FE", bus.tcnt); end
    tick(1);
    checks++; if (bus.tcnt !== 8'hFF) begin errors++; $display("FAIL norm_ff got %h want FF", bus.tcnt); end
    checks++; if (bus.ov_flag !== 1'b0) begin errors++; $display("FAIL norm_ov_early got %b want 0", bus.ov_flag); end
    bus.clk_sel = 3'b000;
    bus.clk_sel = 3'b001;
    tick(1);
    checks++; if (bus.tcnt !== 8'h00) begin errors++; $display("FAIL norm_wrap got %h want 00", bus.tcnt); end
    checks++; if (bus.ov_flag !== 1'b1) begin errors++; $display("FAIL norm_ov_set got %b want 1", bus.ov_flag); end
    checks++; if (bus.ocf_flag !== 1'b0) begin errors++; $display("FAIL norm_ocf got %b want 0", bus.ocf_flag); end
    bus.clk_sel = 3'b000; bus.flag_clr = 2'b01;
    tick(1);
    bus.flag_clr = 2'b00;
    checks++; if (bus.ov_flag !== 1'b0) begin errors++; $display("FAIL norm_ov_clr got %b want 0", bus.ov_flag); end
    checks++; if (bus.tcnt !== 8'h00) begin errors++; $display("FAIL norm_stop_hold got %h want 00", bus.tcnt); end
  endtask

  task automatic test_ctc();
    logic exp_oc;
    bus.clk_sel = 3'b000; bus.mode = 2'b01;
    bus.ocr_wr = 1'b1; bus.ocr_wdata = 8'h03;
    bus.tcnt_wr = 1'b1; bus.tcnt_wdata = 8'h00; bus.flag_clr = 2'b11;
    tick(1);
    bus.ocr_wr = 1'b0; bus.tcnt_wr = 1'b0; bus.flag_clr = 2'b00;
    checks++; if (bus.ocr_active !== 8'h03) begin errors++; $display("FAIL ctc_ocr got %h want 03", bus.ocr_active); end
    exp_oc = bus.oc_out;
    checks++; if (exp_oc !== 1'b0) begin errors++; $display("FAIL ctc_oc_init got %b want 0", exp_oc); end
    exp_oc = 1'b0;
    bus.clk_sel = 3'b001; bus.timer_tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k % 4 == 0) exp_oc = ~exp_oc;
      checks++; if (bus.tcnt !== 8'(k % 4)) begin errors++; $display("FAIL ctc_tcnt step %0d got %h want %h", k, bus.tcnt, 8'(k % 4)); end
      checks++; if (bus.oc_out !== exp_oc) begin errors++; $display("FAIL ctc_oc step %0d got %b want %b", k, bus.oc_out, exp_oc); end
    end
    checks++; if (bus.ocf_flag !== 1'b1) begin errors++; $display("FAIL ctc_ocf got %b want 1", bus.ocf_flag); end
    checks++; if (bus.ov_flag !== 1'b0) begin errors++; $display("FAIL ctc_ov got %b want 0", bus.ov_flag); end
  endtask

  task automatic test_pwm();
    int highs;
    bus.clk_sel = 3'b000; bus.mode = 2'b00;
    bus.ocr_wr = 1'b1; bus.ocr_wdata = 8'h3F;
    bus.tcnt_wr = 1'b1; bus.tcnt_wdata = 8'h00; bus.flag_clr = 2'b11;
    tick(1);
    bus.ocr_wr = 1'b0; bus.tcnt_wr = 1'b0; bus.flag_clr = 2'b00;
    bus.mode = 2'b10;
    tick(1);
    checks++; if (bus.ocr_active !== 8'h3F) begin errors++; $display("FAIL pwm_ocr_init got %h want 3F", bus.ocr_active); end
    bus.clk_sel = 3'b001; bus.timer_tick = 1'b1;
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      tick(1);
      if (bus.oc_out === 1'b1) highs++;
    end
    checks++; if (highs !== 64) begin errors++; $display("FAIL pwm_duty_3f got %0d want 64", highs); end
    checks++; if (bus.ov_flag !== 1'b1) begin errors++; $display("FAIL pwm_ov got %b want 1", bus.ov_flag); end
    tick(100);
    bus.ocr_wr = 1'b1; bus.ocr_wdata = 8'h7F;
    tick(1);
    bus.ocr_wr = 1'b0;
    checks++; if (bus.ocr_active !== 8'h3F) begin errors++; $display("FAIL pwm_ocr_buffered got %h want 3F", bus.ocr_active); end
    tick(154);
    checks++; if (bus.tcnt !== 8'hFF) begin errors++; $display("FAIL pwm_at_max got %h want FF", bus.tcnt); end
    checks++; if (bus.ocr_active !== 8'h3F) begin errors++; $display("FAIL pwm_ocr_pre_wrap got %h want 3F", bus.ocr_active); end
    tick(1);
    checks++; if (bus.ocr_active !== 8'h7F) begin errors++; $display("FAIL pwm_ocr_wrap got %h want 7F", bus.ocr_active); end
    highs = (bus.oc_out === 1'b1) ? 1 : 0;
    for (int k = 1; k < 256; k++) begin
      tick(1);
      if (bus.oc_out === 1'b1) highs++;
    end
    checks++; if (highs !== 128) begin errors++; $display("FAIL pwm_duty_7f got %0d want 128", highs); end
  endtask

  task automatic test_ext_clock();
    bus.clk_sel = 3'b000; bus.mode = 2'b00; bus.timer_tick = 1'b0;
    bus.tcnt_wr = 1'b1; bus.tcnt_wdata = 8'h00;
    tick(1);
    bus.tcnt_wr = 1'b0; bus.clk_sel = 3'b111;
    tick(5);
    for (int i = 0; i < 5; i++) begin
      bus.t_pin = 1'b1;
      tick(2);
      checks++; if (bus.tcnt !== 8'(i)) begin errors++; $display("FAIL rise_early %0d got %h want %h", i, bus.tcnt, 8'(i)); end
      tick(1);
      checks++; if (bus.tcnt !== 8'(i + 1)) begin errors++; $display("FAIL rise_count %0d got %h want %h", i, bus.tcnt, 8'(i + 1)); end
      bus.t_pin = 1'b0;
      tick(7);
    end
    checks++; if (bus.tcnt !== 8'h05) begin errors++; $display("FAIL rise_total got %h want 05", bus.tcnt); end
    bus.clk_sel = 3'b110;
    bus.tcnt_wr = 1'b1; bus.tcnt_wdata = 8'h00;
    tick(1);
    bus.tcnt_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.t_pin = 1'b1;
      tick(10);
      checks++; if (bus.tcnt !== 8'(i)) begin errors++; $display("FAIL fall_on_rise %0d got %h want %h", i, bus.tcnt, 8'(i)); end
      bus.t_pin = 1'b0;
      tick(2);
      checks++; if (bus.tcnt !== 8'(i)) begin errors++; $display("FAIL fall_early %0d got %h want %h", i, bus.tcnt, 8'(i)); end
      tick(1);
      checks++; if (bus.tcnt !== 8'(i + 1)) begin errors++; $display("FAIL fall_count %0d got %h want %h", i, bus.tcnt, 8'(i + 1)); end
      tick(7);
    end
    checks++; if (bus.tcnt !== 8'h05) begin errors++; $display("FAIL fall_total got %h want 05", bus.tcnt); end
  endtask

  task automatic test_write_priority();
    bus.clk_sel = 3'b000; bus.mode = 2'b00;
    bus.ocr_wr = 1'b1; bus.ocr_wdata = 8'h10;
    bus.tcnt_wr = 1'b1; bus.tcnt_wdata = 8'h10; bus.flag_clr = 2'b11;
    tick(1);
    bus.ocr_wr = 1'b0; bus.flag_clr = 2'b00;
    bus.clk_sel = 3'b001; bus.timer_tick = 1'b1;
    tick(1);
    bus.tcnt_wr = 1'b0;
    checks++; if (bus.tcnt !== 8'h10) begin errors++; $display("FAIL wr_prio_tcnt got %h want 10", bus.tcnt); end
    checks++; if (bus.ocf_flag !== 1'b0) begin errors++; $display("FAIL wr_prio_ocf got %b want 0", bus.ocf_flag); end
    checks++; if (bus.oc_out !== 1'b0) begin errors++; $display("FAIL wr_prio_oc got %b want 0", bus.oc_out); end
    bus.flag_clr = 2'b10;
    tick(1);
    bus.flag_clr = 2'b00;
    checks++; if (bus.tcnt !== 8'h11) begin errors++; $display("FAIL set_wins_tcnt got %h want 11", bus.tcnt); end
    checks++; if (bus.ocf_flag !== 1'b1) begin errors++; $display("FAIL set_wins_ocf got %b want 1", bus.ocf_flag); end
    checks++; if (bus.oc_out !== 1'b1) begin errors++; $display("FAIL set_wins_oc got %b want 1", bus.oc_out); end
  endtask

  task automatic test_reset_mid_count();
    idle_inputs();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus.ocr_wr = 1'b1; bus.ocr_wdata = 8'h54;
    bus.tcnt_wr = 1'b1; bus.tcnt_wdata = 8'hFF;
    tick(1);
    bus.ocr_wr = 1'b0; bus.tcnt_wr = 1'b0;
    bus.clk_sel = 3'b001; bus.timer_tick = 1'b1;
    tick(1);
    checks++; if (bus.ov_flag !== 1'b1) begin errors++; $display("FAIL mid_ov_setup got %b want 1", bus.ov_flag); end
    bus.tcnt_wr = 1'b1; bus.tcnt_wdata = 8'h54;
    tick(1);
    bus.tcnt_wr = 1'b0;
    tick(1);
    checks++; if (bus.tcnt !== 8'h55) begin errors++; $display("FAIL mid_tcnt_setup got %h want 55", bus.tcnt); end
    checks++; if (bus.oc_out !== 1'b1) begin errors++; $display("FAIL mid_oc_setup got %b want 1", bus.oc_out); end
    checks++; if (bus.ocf_flag !== 1'b1) begin errors++; $display("FAIL mid_ocf_setup got %b want 1", bus.ocf_flag); end
    reset = 1'b1;
    #2;
    checks++; if (bus.tcnt !== 8'h00) begin errors++; $display("FAIL async_tcnt got %h want 00", bus.tcnt); end
    checks++; if (bus.ocr_active !== 8'h00) begin errors++; $display("FAIL async_ocr got %h want 00", bus.ocr_active); end
    checks++; if (bus.ov_flag !== 1'b0) begin errors++; $display("FAIL async_ov got %b want 0", bus.ov_flag); end
    checks++; if (bus.ocf_flag !== 1'b0) begin errors++; $display("FAIL async_ocf got %b want 0", bus.ocf_flag); end
    checks++; if (bus.oc_out !== 1'b0) begin errors++; $display("FAIL async_oc got %b want 0", bus.oc_out); end
    #1;
    reset = 1'b0;
    tick(1);
    checks++; if (bus.tcnt !== 8'h01) begin errors++; $display("FAIL resume_1 got %h want 01", bus.tcnt); end
    tick(2);
    checks++; if (bus.tcnt !== 8'h03) begin errors++; $display("FAIL resume_3 got %h want 03", bus.tcnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.t_pin = 1'b0;
    idle_inputs();
    test_reset();
    test_normal();
    test_ctc();
    test_pwm();
    test_ext_clock();
    test_write_priority();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
